// File: rtl/prog_loader_ctrl.sv
// Boot loader: streams i_in_* words to memory at i_load_base (write 1 cycle after handshake; source stalls via i_in_valid),
// then releases the CPU SETTLE_CYC cycles after the last write. PROG_LOADER_CHECKSUM_EN adds i_exp_sum verification.
module prog_loader_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int MEM_DEPTH  = 2048,
  parameter int SETTLE_CYC = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load_start,
  input  logic [ADDR_W-1:0] i_load_base,
  input  logic [ADDR_W:0]   i_load_len,
`ifdef PROG_LOADER_CHECKSUM_EN
  input  logic [DATA_W-1:0] i_exp_sum,
`endif
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  input  logic              i_cpu_wen,
  input  logic [ADDR_W-1:0] i_cpu_wadrs,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_wadrs,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);
  localparam int                SW             = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0]     LP_SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [ADDR_W+1:0] LP_DEPTH       = (ADDR_W+2)'(MEM_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_FAULT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_cnt;
  logic [SW-1:0]     r_settle;
  logic              r_cpu_en;
  logic              r_done;
  logic              r_error;
  logic              r_ld_wen;
  logic [ADDR_W-1:0] r_ld_wadrs;
  logic [DATA_W-1:0] r_ld_wdata;

  logic              w_accept;
  logic              w_range_bad;
  logic              w_in_ready;
  logic              w_xfer;
  logic              w_last;
  logic              w_sum_ok;
  logic              w_run;
  logic [ADDR_W:0]   w_cnt_next;
  logic [ADDR_W+1:0] w_end;

  assign w_accept    = i_load_start & ((r_state == S_IDLE) | (r_state == S_RUN) | (r_state == S_FAULT));
  assign w_end       = {2'b00, i_load_base} + {1'b0, i_load_len};
  assign w_range_bad = (w_end > LP_DEPTH);
  assign w_in_ready  = (r_state == S_LOAD) && (r_cnt < r_len);
  assign w_xfer      = i_in_valid & w_in_ready;
  assign w_cnt_next  = r_cnt + {{ADDR_W{1'b0}}, w_xfer};
  // Covers len=0 too: LOAD leaves on its first cycle when nothing is owed.
  assign w_last      = (r_state == S_LOAD) && (w_cnt_next == r_len);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_sum;
  logic [DATA_W-1:0] r_exp_sum;
  logic [DATA_W-1:0] w_sum_next;

  assign w_sum_next = r_sum + (w_xfer ? i_in_data : '0);
  assign w_sum_ok   = (w_sum_next == r_exp_sum);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_sum     <= '0;
      r_exp_sum <= '0;
    end else if (w_accept) begin
      r_sum     <= '0;
      r_exp_sum <= i_exp_sum;
    end else if (w_xfer) begin
      r_sum     <= w_sum_next;
    end
  end
`else
  assign w_sum_ok = 1'b1;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_settle   <= '0;
      r_cpu_en   <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_ld_wen   <= 1'b0;
      r_ld_wadrs <= '0;
      r_ld_wdata <= '0;
    end else begin
      r_done   <= 1'b0;
      r_ld_wen <= w_xfer;
      if (w_xfer) begin
        r_ld_wadrs <= r_base + r_cnt[ADDR_W-1:0];
        r_ld_wdata <= i_in_data;
        r_cnt      <= w_cnt_next;
      end
      if (w_accept) begin
        r_base   <= i_load_base;
        r_len    <= i_load_len;
        r_cnt    <= '0;
        r_settle <= '0;
        r_cpu_en <= 1'b0;
        if (w_range_bad) begin
          r_state <= S_FAULT;
          r_error <= 1'b1;
        end else begin
          r_state <= S_LOAD;
          r_error <= 1'b0;
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_last) begin
              if (w_sum_ok) begin
                r_state <= S_SETTLE;
              end else begin
                r_state <= S_FAULT;
                r_error <= 1'b1;
              end
            end
          end
          S_SETTLE: begin
            if (r_settle == LP_SETTLE_LAST) begin
              r_state  <= S_RUN;
              r_cpu_en <= 1'b1;
              r_done   <= 1'b1;
              r_settle <= '0;
            end else begin
              r_settle <= r_settle + SW'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The CPU owns the memory port only while RUN; elsewhere the loader drives it or it idles.
  assign w_run       = (r_state == S_RUN);
  assign o_mem_wen   = w_run ? i_cpu_wen   : r_ld_wen;
  assign o_mem_wadrs = w_run ? i_cpu_wadrs : r_ld_wadrs;
  assign o_mem_wdata = w_run ? i_cpu_wdata : r_ld_wdata;
  assign o_in_ready  = w_in_ready;
  assign o_cpu_en    = r_cpu_en;
  assign o_busy      = (r_state == S_LOAD) | (r_state == S_SETTLE);
  assign o_done      = r_done;
  assign o_error     = r_error;
endmodule

// File: tb/tb_prog_loader_ctrl.sv
// Self-checking bench for prog_loader_ctrl: directed scenarios plus randomized loads against a write-list reference model.
module tb_prog_loader_ctrl;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 11;
  localparam int MEM_DEPTH  = 2048;
  localparam int SETTLE_CYC = 2;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              i_reset;
  logic              i_load_start;
  logic [ADDR_W-1:0] i_load_base;
  logic [ADDR_W:0]   i_load_len;
  logic [DATA_W-1:0] tb_exp_sum;
  logic              i_in_valid;
  logic [DATA_W-1:0] i_in_data;
  logic              o_in_ready;
  logic              i_cpu_wen;
  logic [ADDR_W-1:0] i_cpu_wadrs;
  logic [DATA_W-1:0] i_cpu_wdata;
  logic              o_mem_wen;
  logic [ADDR_W-1:0] o_mem_wadrs;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              o_cpu_en;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  prog_loader_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_load_start(i_load_start), .i_load_base(i_load_base), .i_load_len(i_load_len),
`ifdef PROG_LOADER_CHECKSUM_EN
    .i_exp_sum(tb_exp_sum),
`endif
    .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
    .i_cpu_wen(i_cpu_wen), .i_cpu_wadrs(i_cpu_wadrs), .i_cpu_wdata(i_cpu_wdata),
    .o_mem_wen(o_mem_wen), .o_mem_wadrs(o_mem_wadrs), .o_mem_wdata(o_mem_wdata),
    .o_cpu_en(o_cpu_en), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  int start_cyc = 0;
  logic [DATA_W-1:0] words [16];

  // Observed traffic, sampled on the falling edge.
  logic [ADDR_W-1:0] wa_q[$];
  logic [DATA_W-1:0] wd_q[$];
  int wr_cyc_q[$];
  int hs_cyc_q[$];
  int done_cyc_q[$];

  always @(negedge clk) begin
    if (o_mem_wen === 1'b1) begin
      wa_q.push_back(o_mem_wadrs);
      wd_q.push_back(o_mem_wdata);
      wr_cyc_q.push_back(cyc);
    end
    if (i_in_valid && o_in_ready) hs_cyc_q.push_back(cyc);
    if (o_done === 1'b1) done_cyc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete(); wr_cyc_q.delete(); hs_cyc_q.delete(); done_cyc_q.delete();
  endtask

  function automatic logic [DATA_W-1:0] sum_words(input int len);
    logic [DATA_W-1:0] s;
    s = '0;
    for (int i = 0; i < len; i++) s = s + words[i];
    return s;
  endfunction

  // 0 = runs, 1 = range reject (no writes), 2 = checksum fault after writes.
  function automatic int predict(input int base, input int len, input logic [DATA_W-1:0] xsum);
    if (base + len > MEM_DEPTH) return 1;
    if (CK_EN && (sum_words(len) != xsum)) return 2;
    return 0;
  endfunction

  task automatic start_load(input int base, input int len, input logic [DATA_W-1:0] xsum);
    i_load_base  = ADDR_W'(base);
    i_load_len   = (ADDR_W+1)'(len);
    tb_exp_sum   = xsum;
    i_load_start = 1'b1;
    start_cyc    = cyc;
    tick();
    i_load_start = 1'b0;
    clear_q();
  endtask

  // mode 0: valid always high, 1: pattern 1,0,0,1,0,1 then high, 2: random valid.
  task automatic finish_load(input int len, input int mode, input bit rej);
    int idx;
    int k;
    logic [5:0] pat;
    logic v;
    logic acc;
    idx = 0;
    k = 0;
    pat = 6'b101001;
    if (rej) begin
      i_in_valid = 1'b1;
      i_in_data  = 32'h5555_AAAA;
      repeat (4) tick();
      i_in_valid = 1'b0;
    end else begin
      while (idx < len && k < 200) begin
        if (mode == 0)      v = 1'b1;
        else if (mode == 1) v = (k < 6) ? pat[k] : 1'b1;
        else                v = 1'($urandom_range(0, 1));
        i_in_valid = v;
        i_in_data  = words[idx];
        @(negedge clk);
        acc = i_in_valid && o_in_ready;
        tick();
        if (acc) idx++;
        k++;
      end
      i_in_valid = 1'b0;
      check("feed_words_accepted", idx, len);
      check("ready_after_last", o_in_ready, 0);
    end
    repeat (SETTLE_CYC + 4) tick();
  endtask

  task automatic verify_load(input int base, input int len, input int outcome, input string tag);
    logic [ADDR_W-1:0] ea;
    if (outcome == 1) begin
      check({tag, "_rej_writes"}, wa_q.size(), 0);
      check({tag, "_rej_error"}, o_error, 1);
      check({tag, "_rej_cpu_en"}, o_cpu_en, 0);
      check({tag, "_rej_busy"}, o_busy, 0);
      check({tag, "_rej_done"}, done_cyc_q.size(), 0);
    end else begin
      check({tag, "_nwrites"}, wa_q.size(), len);
      check({tag, "_nhandshakes"}, hs_cyc_q.size(), len);
      for (int i = 0; i < len && i < wa_q.size(); i++) begin
        ea = ADDR_W'(base + i);
        check({tag, "_addr"}, wa_q[i], ea);
        check({tag, "_data"}, wd_q[i], words[i]);
        if (i < hs_cyc_q.size()) check({tag, "_latency"}, wr_cyc_q[i], hs_cyc_q[i] + 1);
      end
      if (outcome == 0) begin
        check({tag, "_done_pulses"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) begin
          if (len > 0 && wr_cyc_q.size() >= len)
            check({tag, "_done_time"}, done_cyc_q[0], wr_cyc_q[len-1] + SETTLE_CYC);
          else
            check({tag, "_done_time"}, done_cyc_q[0], start_cyc + 2 + SETTLE_CYC);
        end
        check({tag, "_cpu_en"}, o_cpu_en, 1);
        check({tag, "_error"}, o_error, 0);
      end else begin
        check({tag, "_ck_done"}, done_cyc_q.size(), 0);
        check({tag, "_ck_cpu_en"}, o_cpu_en, 0);
        check({tag, "_ck_error"}, o_error, 1);
      end
      check({tag, "_busy"}, o_busy, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_load_start = 1'b0; i_load_base = '0; i_load_len = '0; tb_exp_sum = '0;
    i_in_valid = 1'b0; i_in_data = '0; i_cpu_wen = 1'b0; i_cpu_wadrs = '0; i_cpu_wdata = '0;
    #2;
    check("rst_mem_wen", o_mem_wen, 0);
    check("rst_mem_wadrs", o_mem_wadrs, 0);
    check("rst_mem_wdata", o_mem_wdata, 0);
    check("rst_cpu_en", o_cpu_en, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_error", o_error, 0);
    check("rst_in_ready", o_in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    tick();
    check("idle_cpu_en", o_cpu_en, 0);

    // Basic load at 0x010
    for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
    start_load(16, 4, sum_words(4));
    check("basic_busy", o_busy, 1);
    finish_load(4, 0, 1'b0);
    verify_load(16, 4, 0, "basic");

    // Stalling source
    for (int i = 0; i < 3; i++) words[i] = $urandom;
    start_load(0, 3, sum_words(3));
    finish_load(3, 1, 1'b0);
    verify_load(0, 3, 0, "stall");

    // Range reject, then boundary-exact load that clears error
    start_load(2040, 9, 0);
    finish_load(9, 0, 1'b1);
    verify_load(2040, 9, 1, "range");
    for (int i = 0; i < 8; i++) words[i] = $urandom;
    start_load(2040, 8, sum_words(8));
    check("range_err_cleared", o_error, 0);
    finish_load(8, 0, 1'b0);
    verify_load(2040, 8, 0, "edge");

    // RUN passthrough, then reload from RUN
    clear_q();
    i_cpu_wen = 1'b1; i_cpu_wadrs = 11'h100; i_cpu_wdata = 32'hDEAD;
    @(negedge clk);
    check("run_pass_wen", o_mem_wen, 1);
    check("run_pass_adrs", o_mem_wadrs, 11'h100);
    check("run_pass_data", o_mem_wdata, 32'hDEAD);
    tick();
    words[0] = $urandom; words[1] = $urandom;
    i_cpu_wadrs = 11'h101; i_cpu_wdata = 32'hBEEF;
    i_load_base = 11'h030; i_load_len = 12'd2; tb_exp_sum = sum_words(2);
    i_load_start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    check("start_cyc_pass_wen", o_mem_wen, 1);
    check("start_cyc_pass_adrs", o_mem_wadrs, 11'h101);
    check("start_cyc_pass_data", o_mem_wdata, 32'hBEEF);
    check("start_cyc_cpu_en", o_cpu_en, 1);
    tick();
    i_load_start = 1'b0;
    clear_q();
    check("reload_cpu_en_fall", o_cpu_en, 0);
    repeat (3) begin
      @(negedge clk);
      check("cpu_write_dropped", o_mem_wen, 0);
      tick();
    end
    i_cpu_wen = 1'b0;
    finish_load(2, 0, 1'b0);
    verify_load(48, 2, 0, "reload");

    // Reset after 2 of 5 words
    for (int i = 0; i < 5; i++) words[i] = $urandom;
    start_load(32, 5, sum_words(5));
    i_in_valid = 1'b1; i_in_data = words[0];
    tick();
    i_in_data = words[1];
    tick();
    i_in_valid = 1'b0;
    @(negedge clk);
    #1;
    i_reset = 1'b1;
    #1;
    check("midrst_writes_before", wa_q.size(), 2);
    check("midrst_mem_wen", o_mem_wen, 0);
    check("midrst_mem_wadrs", o_mem_wadrs, 0);
    check("midrst_cpu_en", o_cpu_en, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_in_ready", o_in_ready, 0);
    check("midrst_error", o_error, 0);
    tick();
    i_reset = 1'b0;
    clear_q();
    i_in_valid = 1'b1;
    repeat (4) tick();
    i_in_valid = 1'b0;
    check("midrst_no_writes", wa_q.size(), 0);
    start_load(32, 5, sum_words(5));
    finish_load(5, 2, 1'b0);
    verify_load(32, 5, 0, "restart");

    // Randomized loads against the model
    for (int t = 0; t < 10; t++) begin
      int b;
      int l;
      int oc;
      logic [DATA_W-1:0] xs;
      l = $urandom_range(0, 8);
      if ($urandom_range(0, 2) == 0) b = $urandom_range(MEM_DEPTH - 10, MEM_DEPTH - 1);
      else                           b = $urandom_range(0, MEM_DEPTH - 1);
      for (int i = 0; i < l; i++) words[i] = $urandom;
      xs = sum_words(l);
      if (CK_EN && $urandom_range(0, 3) == 0) xs = xs ^ 32'h1;
      oc = predict(b, l, xs);
      start_load(b, l, xs);
      finish_load(l, 2, oc == 1);
      verify_load(b, l, oc, "rand");
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3;
    start_load(64, 3, 32'd6);
    finish_load(3, 0, 1'b0);
    verify_load(64, 3, 0, "cksum_ok");
    start_load(64, 3, 32'd7);
    finish_load(3, 0, 1'b0);
    verify_load(64, 3, 2, "cksum_bad");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
